y_scale_coef_fetch: RTL and testbench

Y_SCALE_COEF_FETCH -- requirements
Module: y_scale_coef_fetch

---
 rtl/y_scale_coef_fetch.sv | 143 ++++++++++++++
 tb/tb_y_scale_coef_fetch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/y_scale_coef_fetch.sv
// y_scale_coef_fetch: walks the vertical scaler position for one frame.
// For each output row it fetches a coefficient word from the y-scale ROM,
// then presents the source row index and coefficient with valid/ready.
// Optional feature: define Y_SCALE_CLAMP_EN to clamp the source row to src_h-1.
module y_scale_coef_fetch #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int ROW_WIDTH   = 12,
    parameter int FRAC_WIDTH  = 16,
    parameter int ROM_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [ROW_WIDTH-1:0]            dst_h,
    input  logic [ROW_WIDTH-1:0]            src_h,
    input  logic [ROW_WIDTH+FRAC_WIDTH-1:0] step,
    output logic                            busy,
    output logic                            done,
    output logic [ADDR_WIDTH-1:0]           rom_addr,
    input  logic [DATA_WIDTH-1:0]           rom_data,
    output logic                            o_valid,
    input  logic                            o_ready,
    output logic [ROW_WIDTH-1:0]            o_src_row,
    output logic [DATA_WIDTH-1:0]           o_coef,
    output logic                            o_last
);

    localparam int POS_WIDTH = ROW_WIDTH + FRAC_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    // Last count value of the WAIT phase (ROM_LATENCY is 1 or 2).
    localparam logic [1:0]           WAIT_LAST = 2'(ROM_LATENCY - 1);
    localparam logic [ROW_WIDTH-1:0] ROW_ONE   = ROW_WIDTH'(1);

    logic [1:0]           state;
    logic [1:0]           wait_cnt;
    logic [ROW_WIDTH-1:0] dst_h_q;
    logic [ROW_WIDTH-1:0] src_h_q;
    logic [ROW_WIDTH-1:0] row_cnt;
    logic [POS_WIDTH-1:0] step_q;
    logic [POS_WIDTH-1:0] pos;
    logic [ROW_WIDTH-1:0] pos_int;
    logic [ROW_WIDTH-1:0] src_row_next;
    logic                 handshake;

    assign busy      = (state != S_IDLE);
    assign handshake = o_valid && o_ready;
    assign pos_int   = pos[POS_WIDTH-1:FRAC_WIDTH];

`ifdef Y_SCALE_CLAMP_EN
    // Clamp the source row into [0, src_h-1]; an empty source maps to row 0.
    always_comb begin
        // NOTE: default assignment first so no path leaves the output unassigned (no latch).
        src_row_next = pos_int;
        if (src_h_q == '0) begin
            src_row_next = '0;
        end else if (pos_int > (src_h_q - ROW_ONE)) begin
            src_row_next = src_h_q - ROW_ONE;
        end
    end
`else
    // Without clamping the integer part of the position is used as-is.
    assign src_row_next = pos_int;

    // src_h is latched for interface compatibility but does not affect output.
    logic unused_src_h;
    assign unused_src_h = ^src_h_q;
`endif

    // Frame sequencer: ADDR -> WAIT (ROM latency) -> OUT (handshake) per row.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all sequential state avoid evaluation-order races.
            state     <= S_IDLE;
            wait_cnt  <= '0;
            dst_h_q   <= '0;
            src_h_q   <= '0;
            step_q    <= '0;
            pos       <= '0;
            row_cnt   <= '0;
            done      <= 1'b0;
            rom_addr  <= '0;
            o_valid   <= 1'b0;
            o_src_row <= '0;
            o_coef    <= '0;
            o_last    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dst_h_q <= dst_h;
                        src_h_q <= src_h;
                        step_q  <= step;
                        pos     <= '0;
                        row_cnt <= '0;
                        if (dst_h == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    rom_addr <= pos[FRAC_WIDTH-1 -: ADDR_WIDTH];
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        o_coef    <= rom_data;
                        o_src_row <= src_row_next;
                        o_last    <= (row_cnt == (dst_h_q - ROW_ONE));
                        o_valid   <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                S_OUT: begin
                    if (handshake) begin
                        o_valid <= 1'b0;
                        pos     <= pos + step_q;
                        row_cnt <= row_cnt + ROW_ONE;
                        if (o_last) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            state <= S_ADDR;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_y_scale_coef_fetch.sv
// Self-checking bench for y_scale_coef_fetch. Expected rows come from a
// closed-form model: row i sits at position i*step (mod 2^(ROW+FRAC)).
module tb_y_scale_coef_fetch;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int RW  = 12;
    localparam int FW  = 16;
    localparam int LAT = 1;
    localparam int PW  = RW + FW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [RW-1:0] dst_h;
    logic [RW-1:0] src_h;
    logic [PW-1:0] step;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          o_valid;
    logic          o_ready;
    logic [RW-1:0] o_src_row;
    logic [DW-1:0] o_coef;
    logic          o_last;

    int n_chk  = 0;
    int n_pass = 0;

    y_scale_coef_fetch #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ROW_WIDTH  (RW),
        .FRAC_WIDTH (FW),
        .ROM_LATENCY(LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dst_h    (dst_h),
        .src_h    (src_h),
        .step     (step),
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_src_row(o_src_row),
        .o_coef   (o_coef),
        .o_last   (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coefficient ROM contents: a distinct word per address.
    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return {a, 6'h2A, ~a, 6'h15};
    endfunction

    // Single-cycle ROM: data is valid one cycle after the address changes.
    assign rom_data = rom_fn(rom_addr);

    // Position of output row idx.
    function automatic logic [PW-1:0] pos_of(input int idx, input logic [PW-1:0] st);
        longint p;
        p = longint'(idx) * longint'(st);
        return p[PW-1:0];
    endfunction

    function automatic logic [RW-1:0] exp_row(input logic [PW-1:0] p, input logic [RW-1:0] sh);
        int r;
        r = int'(p[PW-1:FW]);
`ifdef Y_SCALE_CLAMP_EN
        if (sh == 0) r = 0;
        else if (r > int'(sh) - 1) r = int'(sh) - 1;
`endif
        return RW'(r);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Run one frame; optionally stall one row for 5 cycles and/or pulse start while busy.
    task automatic run_frame(input logic [RW-1:0] dh, input logic [RW-1:0] sh,
                             input logic [PW-1:0] st, input int ready_pct,
                             input bit spam, input int stall_row);
        int row;
        int cyc;
        int dones;
        int stall_cnt;
        int budget;
        bit first_seen;
        logic [PW-1:0] p;
        @(negedge clk);
        start = 1'b1; dst_h = dh; src_h = sh; step = st; o_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        // Scramble the inputs: the frame must use the values latched at start.
        dst_h = RW'($urandom); src_h = RW'($urandom); step = PW'($urandom);
        if (dh == 0) begin
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 0);
            chk("zero_valid", o_valid, 0);
            @(negedge clk);
            chk("zero_done_one", done, 0);
            chk("zero_valid2", o_valid, 0);
            chk("zero_busy2", busy, 0);
            return;
        end
        row = 0; cyc = 1; dones = 0; stall_cnt = 0; first_seen = 0;
        budget = 100 + int'(dh) * 60;
        while (dones == 0 && cyc < budget) begin
            if (o_valid) begin
                if (!first_seen) begin
                    chk("first_valid_latency", cyc, LAT + 2);
                    first_seen = 1;
                end
                p = pos_of(row, st);
                chk("row_in_range", row < int'(dh), 1);
                chk("src_row", o_src_row, exp_row(p, sh));
                chk("rom_addr", rom_addr, p[FW-1 -: AW]);
                chk("coef", o_coef, rom_fn(p[FW-1 -: AW]));
                chk("last", o_last, row == int'(dh) - 1);
            end
            if (done) begin
                dones++;
                chk("rows_at_done", row, dh);
                chk("busy_at_done", busy, 0);
            end else begin
                chk("busy_mid_frame", busy, 1);
            end
            o_ready = ($urandom_range(99) < ready_pct);
            if (o_valid && row == stall_row && stall_cnt < 5) begin
                o_ready = 1'b0;
                stall_cnt++;
            end
            start = spam && busy && ($urandom_range(3) == 0);
            if (spam && o_valid && o_ready && o_last) start = 1'b1;
            if (o_valid && o_ready) row++;
            @(negedge clk);
            cyc++;
        end
        if (dones == 0) chk("frame_timeout", 0, 1);
        start = 1'b0; o_ready = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_after_frame", busy, 0);
        chk("no_valid_after", o_valid, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dst_h = '0; src_h = '0; step = '0; o_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_last", o_last, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_src_row", o_src_row, 0);
        chk("rst_coef", o_coef, 0);
        rst = 1'b0;

        // Half-rate scaling, always ready: rows 0,0,1,1 and addr 0,512,0,512.
        run_frame(12'd4, 12'd2, 28'h0_8000, 100, 1'b0, -1);
        // Same frame with row 2 stalled for 5 cycles.
        run_frame(12'd4, 12'd2, 28'h0_8000, 100, 1'b0, 1);
        // Empty frame.
        run_frame(12'd0, 12'd5, 28'h1_0000, 100, 1'b0, -1);
        // Step of two rows: clamping changes the last row.
        run_frame(12'd3, 12'd4, 28'h2_0000, 100, 1'b0, -1);

        // Reset while in WAIT of row 2.
        @(negedge clk);
        start = 1'b1; dst_h = 12'd4; src_h = 12'd2; step = 28'h0_8000; o_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_valid", o_valid, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_addr", rom_addr, 0);
        chk("mid_rst_src_row", o_src_row, 0);
        chk("mid_rst_coef", o_coef, 0);
        chk("mid_rst_last", o_last, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", done, 0);
            chk("post_rst_idle", busy, 0);
        end
        run_frame(12'd4, 12'd2, 28'h0_8000, 100, 1'b0, -1);

        // Start pulses while busy, including the final handshake.
        run_frame(12'd4, 12'd2, 28'h0_8000, 70, 1'b1, -1);

        // Randomized frames.
        for (int f = 0; f < 10; f++) begin
            logic [RW-1:0] dh;
            logic [RW-1:0] sh;
            logic [PW-1:0] st;
            dh = RW'($urandom_range(0, 6));
            sh = RW'($urandom_range(0, 9));
            if ($urandom_range(3) == 0) st = PW'($urandom);
            else st = PW'($urandom_range(0, 32'h3_FFFF));
            run_frame(dh, sh, st, int'($urandom_range(30, 100)), bit'($urandom_range(1)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
